multi_channel_data_synchronizer: RTL and testbench

Multi-channel successor to the single-bus data synchronizer. It carries CHANNEL_COUNT independent asynchronous buses into the destination clock domain. Each channel has its own STAGE_COUNT-flop valid synchronizer, pulse generator and holding register, and each channel returns a level acknowledge to its source. A round-robin arbiter serialises the captured words onto one synchronous output bus, tagged with the channel number, at one word per cycle.

---
 rtl/multi_channel_data_synchronizer.sv | 121 ++++++++++++
 tb/tb_multi_channel_data_synchronizer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_data_synchronizer.sv
// Carries CHANNEL_COUNT asynchronous valid/data buses into clk and serialises them round-robin onto one tagged output bus.
// Optional macro DATA_SYNC_OVERRUN_EN: a word arriving on a still-pending channel is dropped and overrun_error latches.
module multi_channel_data_synchronizer #(
   parameter int STAGE_COUNT   = 2,
   parameter int BUS_WIDTH     = 4,
   parameter int CHANNEL_COUNT = 4
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [CHANNEL_COUNT-1:0]           asynchronous_data_valid,
   input  logic [CHANNEL_COUNT*BUS_WIDTH-1:0] asynchronous_data,
   output logic [CHANNEL_COUNT-1:0]           asynchronous_data_ack,
   output logic [BUS_WIDTH-1:0]               synchronous_data,
   output logic [$clog2(CHANNEL_COUNT)-1:0]   synchronous_channel,
   output logic                               synchronous_data_valid,
   output logic [CHANNEL_COUNT-1:0]           overrun_error
);

   localparam int CH_W = $clog2(CHANNEL_COUNT);

   logic [CHANNEL_COUNT-1:0] sync_q [STAGE_COUNT];
   logic [CHANNEL_COUNT-1:0] prev_q;
   logic [CHANNEL_COUNT-1:0] pending_q;
   logic [CHANNEL_COUNT-1:0] pending_d;
   logic [CHANNEL_COUNT-1:0] err_q;
   logic [CHANNEL_COUNT-1:0] err_d;
   logic [BUS_WIDTH-1:0]     hold_q [CHANNEL_COUNT];
   logic [CH_W-1:0]          last_grant_q;
   logic [BUS_WIDTH-1:0]     data_q;
   logic [CH_W-1:0]          chan_q;
   logic                     valid_q;

   logic [CHANNEL_COUNT-1:0] pulse_s;
   logic [CHANNEL_COUNT-1:0] load_s;
   logic [CHANNEL_COUNT-1:0] gnt_oh_s;
   logic [CH_W-1:0]          gnt_idx_s;
   logic [CH_W-1:0]          cand_s;
   logic                     gnt_any_s;

   // Valid synchroniser chains plus the previous-value flop of each channel
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < STAGE_COUNT; s++) begin
            sync_q[s] <= '0;
         end
         prev_q <= '0;
      end else begin
         sync_q[0] <= asynchronous_data_valid;
         for (int s = 1; s < STAGE_COUNT; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
         prev_q <= sync_q[STAGE_COUNT-1];
      end
   end

   // Round-robin search starting one past the last granted channel
   always_comb begin
      gnt_any_s = 1'b0;
      gnt_idx_s = last_grant_q;
      cand_s    = last_grant_q;
      for (int i = 1; i <= CHANNEL_COUNT; i++) begin
         cand_s = CH_W'((32'(last_grant_q) + 32'(i)) % CHANNEL_COUNT);
         if (!gnt_any_s && pending_q[cand_s]) begin
            gnt_any_s = 1'b1;
            gnt_idx_s = cand_s;
         end else begin
            gnt_any_s = gnt_any_s;
         end
      end
      gnt_oh_s = gnt_any_s ? (CHANNEL_COUNT'(1'b1) << gnt_idx_s) : '0;
   end

   // Capture decision; a capture on the channel being granted is never an overrun
   always_comb begin
      pulse_s   = sync_q[STAGE_COUNT-1] & ~prev_q;
      pending_d = (pending_q & ~gnt_oh_s) | pulse_s;
`ifdef DATA_SYNC_OVERRUN_EN
      load_s    = pulse_s & ~(pending_q & ~gnt_oh_s);
      err_d     = err_q | (pulse_s & pending_q & ~gnt_oh_s);
`else
      load_s    = pulse_s;
      err_d     = '0;
`endif
   end

   // Holding registers, pending flags and the registered output word
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < CHANNEL_COUNT; c++) begin
            hold_q[c] <= '0;
         end
         pending_q    <= '0;
         err_q        <= '0;
         last_grant_q <= CH_W'(CHANNEL_COUNT - 1);
         data_q       <= '0;
         chan_q       <= '0;
         valid_q      <= 1'b0;
      end else begin
         for (int c = 0; c < CHANNEL_COUNT; c++) begin
            if (load_s[c]) begin
               hold_q[c] <= asynchronous_data[c*BUS_WIDTH +: BUS_WIDTH];
            end
         end
         pending_q <= pending_d;
         err_q     <= err_d;
         valid_q   <= gnt_any_s;
         if (gnt_any_s) begin
            data_q       <= hold_q[gnt_idx_s];
            chan_q       <= gnt_idx_s;
            last_grant_q <= gnt_idx_s;
         end
      end
   end

   assign asynchronous_data_ack  = prev_q;
   assign synchronous_data       = data_q;
   assign synchronous_channel    = chan_q;
   assign synchronous_data_valid = valid_q;
   assign overrun_error          = err_q;

endmodule

// File: tb/tb_multi_channel_data_synchronizer.sv
// Directed self-checking bench for multi_channel_data_synchronizer (default parameters).
module tb_multi_channel_data_synchronizer;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  v;
   logic [15:0] d;
   logic [3:0]  ack;
   logic [3:0]  sd;
   logic [1:0]  sch;
   logic        sv;
   logic [3:0]  err;
   int          checks = 0;
   int          failures = 0;

   multi_channel_data_synchronizer #(
      .STAGE_COUNT(2), .BUS_WIDTH(4), .CHANNEL_COUNT(4)
   ) dut (
      .clk                    (clk),
      .reset                  (reset),
      .asynchronous_data_valid(v),
      .asynchronous_data      (d),
      .asynchronous_data_ack  (ack),
      .synchronous_data       (sd),
      .synchronous_channel    (sch),
      .synchronous_data_valid (sv),
      .overrun_error          (err)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      v = 4'h0;
      d = 16'h0000;
      repeat (2) tick();
      reset = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
         v = 4'($urandom);
         d = 16'($urandom);
         tick();
         checks++;
         if ({ack, sd, sch, sv, err} !== 15'h0000) begin
            failures++;
            $display("FAIL reset_hold cyc=%0d got ack=%h sd=%h ch=%0d sv=%b err=%h expected all 0", k, ack, sd, sch, sv, err);
         end
      end
      reset = 1'b0;
      tick();
      checks++;
      if ({ack, sd, sch, sv, err} !== 15'h0000) begin
         failures++;
         $display("FAIL reset_release got ack=%h sd=%h ch=%0d sv=%b err=%h expected all 0", ack, sd, sch, sv, err);
      end
      v = 4'h0;
      repeat (8) tick();
   endtask

   task automatic test_single;
      do_reset();
      d[11:8] = 4'hA;
      v[2] = 1'b1;
      tick();
      tick();
      checks++;
      if (ack !== 4'h0 || sv !== 1'b0) begin
         failures++;
         $display("FAIL single_edge2 got ack=%h sv=%b expected ack=0 sv=0", ack, sv);
      end
      tick();
      checks++;
      if (ack !== 4'b0100 || sv !== 1'b0) begin
         failures++;
         $display("FAIL single_ack_rise got ack=%h sv=%b expected ack=4 sv=0", ack, sv);
      end
      tick();
      checks++;
      if (sv !== 1'b1 || sd !== 4'hA || sch !== 2'd2) begin
         failures++;
         $display("FAIL single_strobe got sv=%b sd=%h ch=%0d expected sv=1 sd=a ch=2", sv, sd, sch);
      end
      tick();
      checks++;
      if (sv !== 1'b0) begin
         failures++;
         $display("FAIL single_one_cycle got sv=%b expected 0", sv);
      end
      v[2] = 1'b0;
      tick();
      tick();
      checks++;
      if (ack !== 4'b0100) begin
         failures++;
         $display("FAIL single_ack_hold got ack=%h expected 4", ack);
      end
      tick();
      checks++;
      if (ack !== 4'h0) begin
         failures++;
         $display("FAIL single_ack_fall got ack=%h expected 0", ack);
      end
   endtask

   task automatic test_simultaneous;
      logic [1:0] exp_ch [3] = '{2'd0, 2'd1, 2'd3};
      logic [3:0] exp_d  [3] = '{4'h3, 4'h5, 4'hC};
      do_reset();
      d = {4'hC, 4'h0, 4'h5, 4'h3};
      v = 4'b1011;
      repeat (3) tick();
      checks++;
      if (ack !== 4'b1011 || sv !== 1'b0) begin
         failures++;
         $display("FAIL simul_ack got ack=%h sv=%b expected ack=b sv=0", ack, sv);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (sv !== 1'b1 || sch !== exp_ch[k] || sd !== exp_d[k]) begin
            failures++;
            $display("FAIL simul_order k=%0d got sv=%b ch=%0d sd=%h expected sv=1 ch=%0d sd=%h", k, sv, sch, sd, exp_ch[k], exp_d[k]);
         end
      end
      tick();
      checks++;
      if (sv !== 1'b0) begin
         failures++;
         $display("FAIL simul_idle got sv=%b expected 0", sv);
      end
      v = 4'h0;
      repeat (4) tick();
   endtask

   task automatic test_fairness;
      do_reset();
      d[7:4] = 4'h1;
      v = 4'b0010;
      tick();
      d[3:0]  = 4'h6;
      d[11:8] = 4'h9;
      v = 4'b0111;
      repeat (3) tick();
      checks++;
      if (sv !== 1'b1 || sch !== 2'd1 || sd !== 4'h1) begin
         failures++;
         $display("FAIL fair_first got sv=%b ch=%0d sd=%h expected sv=1 ch=1 sd=1", sv, sch, sd);
      end
      tick();
      checks++;
      if (sv !== 1'b1 || sch !== 2'd2 || sd !== 4'h9) begin
         failures++;
         $display("FAIL fair_second got sv=%b ch=%0d sd=%h expected sv=1 ch=2 sd=9", sv, sch, sd);
      end
      tick();
      checks++;
      if (sv !== 1'b1 || sch !== 2'd0 || sd !== 4'h6) begin
         failures++;
         $display("FAIL fair_third got sv=%b ch=%0d sd=%h expected sv=1 ch=0 sd=6", sv, sch, sd);
      end
      tick();
      checks++;
      if (sv !== 1'b0) begin
         failures++;
         $display("FAIL fair_idle got sv=%b expected 0", sv);
      end
      v = 4'h0;
      repeat (4) tick();
   endtask

   task automatic test_overrun;
      logic [3:0] exp_d [4];
      logic [3:0] exp_err;
`ifdef DATA_SYNC_OVERRUN_EN
      exp_d   = '{4'h1, 4'h2, 4'h4, 4'hC};
      exp_err = 4'b1000;
`else
      exp_d   = '{4'h1, 4'h2, 4'h4, 4'h7};
      exp_err = 4'b0000;
`endif
      do_reset();
      d = {4'hC, 4'h4, 4'h2, 4'h1};
      v = 4'b1111;
      tick();
      tick();
      v[3] = 1'b0;
      tick();
      d[15:12] = 4'h7;
      v[3] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (sv !== 1'b1 || sch !== 2'(k) || sd !== exp_d[k]) begin
            failures++;
            $display("FAIL overrun_word k=%0d got sv=%b ch=%0d sd=%h expected sv=1 ch=%0d sd=%h", k, sv, sch, sd, k, exp_d[k]);
         end
      end
      checks++;
      if (err !== exp_err) begin
         failures++;
         $display("FAIL overrun_flag got err=%h expected %h", err, exp_err);
      end
      repeat (3) tick();
      checks++;
      if (sv !== 1'b0 || err !== exp_err) begin
         failures++;
         $display("FAIL overrun_sticky got sv=%b err=%h expected sv=0 err=%h", sv, err, exp_err);
      end
      v = 4'h0;
      repeat (4) tick();
   endtask

   task automatic test_reset_mid;
      do_reset();
      d[7:4]   = 4'h5;
      d[15:12] = 4'hB;
      v = 4'b1010;
      repeat (3) tick();
      checks++;
      if (ack !== 4'b1010 || sv !== 1'b0) begin
         failures++;
         $display("FAIL mid_pending got ack=%h sv=%b expected ack=a sv=0", ack, sv);
      end
      reset = 1'b1;
      v = 4'h0;
      tick();
      tick();
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         checks++;
         if (sv !== 1'b0 || ack !== 4'h0 || err !== 4'h0) begin
            failures++;
            $display("FAIL mid_quiet k=%0d got sv=%b ack=%h err=%h expected all 0", k, sv, ack, err);
         end
      end
      d[7:4] = 4'h9;
      v = 4'b0010;
      repeat (3) tick();
      checks++;
      if (ack !== 4'b0010 || sv !== 1'b0) begin
         failures++;
         $display("FAIL mid_fresh_ack got ack=%h sv=%b expected ack=2 sv=0", ack, sv);
      end
      tick();
      checks++;
      if (sv !== 1'b1 || sch !== 2'd1 || sd !== 4'h9) begin
         failures++;
         $display("FAIL mid_fresh_word got sv=%b ch=%0d sd=%h expected sv=1 ch=1 sd=9", sv, sch, sd);
      end
      v = 4'h0;
      repeat (4) tick();
   endtask

   initial begin
      reset = 1'b0;
      v = 4'h0;
      d = 16'h0000;
      tick();
      test_reset();
      test_single();
      test_simultaneous();
      test_fairness();
      test_overrun();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
